// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Op codes (shared with the entry FSM) and sequencer state encoding.
// Revision : 1.0
// ============================================================================
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Brief    : Request/result bundle between the entry FSM and the ALU sequencer.
// Revision : 1.0
// ============================================================================
interface alu_seq_if #(
    parameter int W = 16
);
    logic         clr;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         res_valid;
    logic [W-1:0] result;
    logic [W-1:0] rem;
    logic         ovf;
    logic         div0;

    modport master (
        output clr, req_valid, op, a, b,
        input  req_ready, busy, res_valid, result, rem, ovf, div0
    );

    modport slave (
        input  clr, req_valid, op, a, b,
        output req_ready, busy, res_valid, result, rem, ovf, div0
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_dp.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_dp
// Brief    : Operand latches, 2W accumulator, iteration counter and the
//            per-cycle shift-add / restoring-divide step.
// Revision : 1.0
// ============================================================================
module alu_seq_dp
    import alu_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         i_load,
    input  wire logic         i_step,
    input  wire logic [1:0]   i_op,
    input  wire logic [W-1:0] i_a,
    input  wire logic [W-1:0] i_b,
    output logic              o_last,
    output logic [W-1:0]      o_nxt_result,
    output logic [W-1:0]      o_nxt_rem,
    output logic              o_nxt_ovf,
    output logic              o_nxt_div0
);

    localparam int               CNT_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    logic [1:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic           w_b_zero;
    logic           w_single;
    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [W:0]     w_mul_add;
    logic [2*W-1:0] w_mul_nxt;
    logic [2*W:0]   w_div_sh;
    logic [W:0]     w_div_trial;
    logic [2*W-1:0] w_div_nxt;

    assign w_b_zero = (r_b == '0);
    assign w_single = (r_op == OP_ADD) || (r_op == OP_SUB) || ((r_op == OP_DIV) && w_b_zero);
    assign o_last   = w_single || (r_cnt == CNT_LAST);

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // MUL: acc = {partial product, remaining multiplier bits}, shifted right each step
    assign w_mul_add = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : {(W+1){1'b0}});
    assign w_mul_nxt = {w_mul_add, r_acc[W-1:1]};

    // DIV: acc = {partial remainder, dividend/quotient}, shifted left each step
    assign w_div_sh    = {r_acc, 1'b0};
    assign w_div_trial = w_div_sh[2*W:W] - {1'b0, r_b};
    assign w_div_nxt   = w_div_trial[W] ? w_div_sh[2*W-1:0]
                                        : {w_div_trial[W-1:0], w_div_sh[W-1:1], 1'b1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_op  <= i_op;
            r_a   <= i_a;
            r_b   <= i_b;
            r_cnt <= '0;
            r_acc <= (i_op == OP_MUL) ? {{W{1'b0}}, i_b} : {{W{1'b0}}, i_a};
        end else if (i_step) begin
            r_acc <= (r_op == OP_MUL) ? w_mul_nxt : w_div_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        o_nxt_result = '0;
        o_nxt_rem    = '0;
        o_nxt_ovf    = 1'b0;
        o_nxt_div0   = 1'b0;
        case (r_op)
            OP_ADD: begin
                o_nxt_result = w_sum[W-1:0];
                o_nxt_ovf    = w_sum[W];
            end
            OP_SUB: begin
                o_nxt_result = w_diff[W-1:0];
                o_nxt_ovf    = w_diff[W];
            end
            OP_MUL: begin
                o_nxt_result = w_mul_nxt[W-1:0];
                o_nxt_ovf    = |w_mul_nxt[2*W-1:W];
            end
            OP_DIV: begin
                if (w_b_zero) begin
                    o_nxt_div0 = 1'b1;
                end else begin
                    o_nxt_result = w_div_nxt[W-1:0];
                    o_nxt_rem    = w_div_nxt[2*W-1:W];
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Multi-cycle ALU sequencer: handshake, IDLE/CALC/DONE control and
//            registered result/status outputs.
// Revision : 1.0
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_seq_if.slave  bus
);

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic         w_accept;
    logic         w_step;
    logic         w_commit;
    logic         w_last;
    logic [W-1:0] w_nxt_result;
    logic [W-1:0] w_nxt_rem;
    logic         w_nxt_ovf;
    logic         w_nxt_div0;

    logic [W-1:0] r_result;
    logic [W-1:0] r_rem;
    logic         r_ovf;
    logic         r_div0;

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid && !bus.clr;
    assign w_step   = (r_state == ST_CALC) && !bus.clr;
    assign w_commit = w_step && w_last;

    alu_seq_dp #(.W(W)) u_dp (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_accept),
        .i_step       (w_step),
        .i_op         (bus.op),
        .i_a          (bus.a),
        .i_b          (bus.b),
        .o_last       (w_last),
        .o_nxt_result (w_nxt_result),
        .o_nxt_rem    (w_nxt_rem),
        .o_nxt_ovf    (w_nxt_ovf),
        .o_nxt_div0   (w_nxt_div0)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
            ST_CALC: begin
                if (bus.clr)     w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (r_state == ST_IDLE) && !bus.clr && reset;
        bus.busy      = (r_state != ST_IDLE);
        bus.res_valid = (r_state == ST_DONE);
    end

    // Aborted operations never reach commit, so outputs keep the last result
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_result <= '0;
            r_rem    <= '0;
            r_ovf    <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_commit) begin
            r_result <= w_nxt_result;
            r_rem    <= w_nxt_rem;
            r_ovf    <= w_nxt_ovf;
            r_div0   <= w_nxt_div0;
        end
    end

    assign bus.result = r_result;
    assign bus.rem    = r_rem;
    assign bus.ovf    = r_ovf;
    assign bus.div0   = r_div0;

endmodule
`default_nettype wire
